// File: rtl/prefix_add_arbiter.sv
// Round-robin arbiter granting NREQ requesters access to one shared adder.
// Each operation runs IDLE (grant) -> EXEC (adder) -> RESP (held result).
module prefix_add_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req_valid,
  output logic [NREQ-1:0] req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ-1:0] req_cin,
  output logic [W-1:0]    add_a,
  output logic [W-1:0]    add_b,
  output logic            add_cin,
  input  logic [W-1:0]    add_sum,
  input  logic            add_carry,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [1:0]      rsp_id,
  output logic [W-1:0]    rsp_sum,
  output logic            rsp_carry
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t state;
  state_t state_nx;

  logic [1:0]   ptr;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         op_cin;
  logic [1:0]   op_id;

  logic [1:0]   gnt_id;
  logic         gnt_any;
  logic         take;

  // Walk downward so the lowest offset from ptr wins.
  always_comb begin
    gnt_id  = ptr;
    gnt_any = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(ptr) + k) % NREQ]) begin
        gnt_id  = 2'((int'(ptr) + k) % NREQ);
        gnt_any = 1'b1;
      end
    end
  end

  assign take = rst_n && (state == IDLE) && gnt_any;

  always_comb begin
    req_ready = '0;
    if (take) begin
      req_ready[gnt_id] = 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (gnt_any) state_nx = EXEC;
      EXEC:    state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_cin    <= 1'b0;
      op_id     <= '0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      rsp_carry <= 1'b0;
    end else begin
      state <= state_nx;
      if (take) begin
        op_a   <= req_a[int'(gnt_id)*W +: W];
        op_b   <= req_b[int'(gnt_id)*W +: W];
        op_cin <= req_cin[gnt_id];
        op_id  <= gnt_id;
        ptr    <= gnt_id + 2'd1;
      end
      if (state == EXEC) begin
        rsp_sum   <= add_sum;
        rsp_carry <= add_carry;
        rsp_id    <= op_id;
      end
    end
  end

  // Operand registers only change on a handshake, so the adder inputs
  // hold steady through IDLE and RESP.
  assign add_a     = op_a;
  assign add_b     = op_b;
  assign add_cin   = op_cin;
  assign rsp_valid = (state == RESP);

endmodule

// File: tb/tb_prefix_add_arbiter.sv
// Bench for prefix_add_arbiter: transaction-level model checked every
// cycle, plus directed scenarios with literal expected results.
module tb_prefix_add_arbiter;

  localparam int N = 4;
  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req_valid = '0;
  logic [N-1:0]  req_ready;
  logic [N*W-1:0] req_a = '0;
  logic [N*W-1:0] req_b = '0;
  logic [N-1:0]  req_cin = '0;
  logic [W-1:0]  add_a;
  logic [W-1:0]  add_b;
  logic          add_cin;
  logic [W-1:0]  add_sum;
  logic          add_carry;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [1:0]    rsp_id;
  logic [W-1:0]  rsp_sum;
  logic          rsp_carry;

  prefix_add_arbiter #(.NREQ(N), .W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_carry(add_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_carry(rsp_carry)
  );

  assign {add_carry, add_sum} = {1'b0, add_a} + {1'b0, add_b} + 17'(add_cin);

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Model: phase 0=waiting for grant, 1=adding, 2=holding response.
  int m_ph, m_ptr, m_id, m_rid;
  int unsigned m_a, m_b, m_cin, m_rsum, m_rcar;

  function automatic int pick();
    for (int k = 0; k < N; k++)
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int g;
    int unsigned tot;
    if (!rst_n) begin
      m_ph = 0; m_ptr = 0; m_id = 0; m_rid = 0;
      m_a = 0; m_b = 0; m_cin = 0; m_rsum = 0; m_rcar = 0;
    end else if (m_ph == 0) begin
      g = pick();
      if (g >= 0) begin
        m_a = req_a[g*W +: W];
        m_b = req_b[g*W +: W];
        m_cin = req_cin[g];
        m_id = g;
        m_ptr = (g + 1) % N;
        m_ph = 1;
      end
    end else if (m_ph == 1) begin
      tot = m_a + m_b + m_cin;
      m_rsum = tot % 65536;
      m_rcar = tot / 65536;
      m_rid = m_id;
      m_ph = 2;
    end else if (rsp_ready) begin
      m_ph = 0;
    end
  end

  always @(negedge clk) begin
    int g;
    logic [31:0] er;
    g = pick();
    er = (rst_n && m_ph == 0 && g >= 0) ? (32'd1 << g) : 32'd0;
    chk("req_ready", 32'(req_ready), er);
    chk("add_a", 32'(add_a), m_a);
    chk("add_b", 32'(add_b), m_b);
    chk("add_cin", 32'(add_cin), m_cin);
    chk("rsp_valid", 32'(rsp_valid), 32'(m_ph == 2));
    chk("rsp_id", 32'(rsp_id), m_rid);
    chk("rsp_sum", 32'(rsp_sum), m_rsum);
    chk("rsp_carry", 32'(rsp_carry), m_rcar);
  end

  // Grant log observed at the DUT boundary.
  int g_id[$];
  int g_cyc[$];
  always @(negedge clk) begin
    for (int i = 0; i < N; i++)
      if (req_valid[i] && req_ready[i]) begin
        g_id.push_back(i);
        g_cyc.push_back(cyc);
      end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rnd_ops();
    req_a = {$urandom(), $urandom()};
    req_b = {$urandom(), $urandom()};
    req_cin = 4'($urandom());
  endtask

  task automatic wait_grant(input int id, output int gc);
    bit ok;
    ok = 0;
    gc = 0;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      if (req_valid[id] && req_ready[id]) begin
        ok = 1;
        gc = cyc;
      end
    end
    chk("grant_seen", 32'(ok), 32'd1);
  endtask

  task automatic wait_rsp(output int rc);
    bit ok;
    ok = 0;
    rc = 0;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      if (rsp_valid) begin
        ok = 1;
        rc = cyc;
      end
    end
    chk("rsp_seen", 32'(ok), 32'd1);
  endtask

  task automatic single(input int id, input logic [15:0] a,
                        input logic [15:0] b, input logic cin,
                        input logic [15:0] es, input logic ec);
    int gc, rc;
    tick();
    rsp_ready = 1'b1;
    req_valid = 4'(1 << id);
    req_a[id*W +: W] = a;
    req_b[id*W +: W] = b;
    req_cin[id] = cin;
    wait_grant(id, gc);
    tick();
    req_valid = '0;
    rnd_ops();
    wait_rsp(rc);
    chk("latency", 32'(rc - gc), 32'd2);
    chk("single_id", 32'(rsp_id), 32'(id));
    chk("single_sum", 32'(rsp_sum), 32'(es));
    chk("single_carry", 32'(rsp_carry), 32'(ec));
  endtask

  initial begin
    int gc, rc, n0;

    // Reset state, with requests already pending.
    req_valid = 4'hF;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_add_a", 32'(add_a), 32'd0);
    tick();
    req_valid = '0;
    rst_n = 1'b1;
    tick();

    // Round robin with every requester asserted.
    rsp_ready = 1'b1;
    rnd_ops();
    g_id.delete();
    g_cyc.delete();
    req_valid = 4'hF;
    for (int t = 0; t < 40 && g_id.size() < 5; t++) @(negedge clk);
    tick();
    req_valid = '0;
    chk("rr_count", 32'(g_id.size() >= 5), 32'd1);
    if (g_id.size() >= 5) begin
      chk("rr_0", 32'(g_id[0]), 32'd0);
      chk("rr_1", 32'(g_id[1]), 32'd1);
      chk("rr_2", 32'(g_id[2]), 32'd2);
      chk("rr_3", 32'(g_id[3]), 32'd3);
      chk("rr_4", 32'(g_id[4]), 32'd0);
      for (int i = 1; i < 5; i++)
        chk("rr_gap", 32'(g_cyc[i] - g_cyc[i-1]), 32'd3);
    end
    repeat (4) tick();

    // Single requests and overflow corners.
    single(2, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
    single(0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
    single(0, 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0);
    repeat (2) tick();

    // Backpressure: response held 5 cycles; ptr=1 so requester 1 wins.
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    req_a[1*W +: W] = 16'h00FF;
    req_b[1*W +: W] = 16'h0F00;
    req_cin[1] = 1'b1;
    wait_grant(1, gc);
    tick();
    req_valid = 4'b1101;
    rnd_ops();
    wait_rsp(rc);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_sum", 32'(rsp_sum), 32'h1000);
      chk("bp_id", 32'(rsp_id), 32'd1);
      chk("bp_carry", 32'(rsp_carry), 32'd0);
      chk("bp_ready", 32'(req_ready), 32'd0);
    end
    tick();
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_hold_last", 32'(rsp_valid), 32'd1);
    @(negedge clk);
    chk("bp_retired", 32'(rsp_valid), 32'd0);
    chk("bp_next_grant", 32'(req_ready), 32'b0100);
    tick();
    req_valid = '0;
    repeat (4) tick();

    // Dropped request: requester 1 pulses during RESP, ptr stays at 1.
    single(0, 16'h0101, 16'h0202, 1'b0, 16'h0303, 1'b0);
    repeat (2) tick();
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    wait_grant(0, gc);
    tick();
    req_valid = '0;
    wait_rsp(rc);
    tick();
    n0 = g_id.size();
    req_valid = 4'b0010;
    @(negedge clk);
    chk("drop_ready", 32'(req_ready), 32'd0);
    tick();
    req_valid = '0;
    tick();
    rsp_ready = 1'b1;
    repeat (4) tick();
    chk("drop_no_grant", 32'(g_id.size()), 32'(n0));
    req_valid = 4'hF;
    wait_grant(1, gc);
    tick();
    req_valid = '0;
    repeat (4) tick();

    // Reset during EXEC; requester 2 leaves a stale ptr of 3.
    req_valid = 4'b0100;
    req_a[2*W +: W] = 16'hABCD;
    req_b[2*W +: W] = 16'h1111;
    req_cin[2] = 1'b1;
    wait_grant(2, gc);
    tick();
    req_valid = 4'hF;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    chk("mid_rst_add_a", 32'(add_a), 32'd0);
    chk("mid_rst_add_b", 32'(add_b), 32'd0);
    chk("mid_rst_add_cin", 32'(add_cin), 32'd0);
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_sum", 32'(rsp_sum), 32'd0);
    chk("mid_rst_id", 32'(rsp_id), 32'd0);
    req_valid = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    tick();
    req_valid = 4'b1001;
    wait_grant(0, gc);
    tick();
    req_valid = '0;
    repeat (4) tick();

    // Randomized traffic against the model.
    for (int t = 0; t < 600; t++) begin
      tick();
      req_valid = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom());
      rsp_ready = ($urandom_range(0, 3) != 0);
      rnd_ops();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (5) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
